// File: rtl/k_fft_pkg.sv
// Shared types and constants for the k_fft sequencer slice.
// Optional per-stage scaling is enabled by defining K_FFTCTRL_STAGE_SCALE_EN.
package k_fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } k_fftctrl_state_t;

    localparam logic [1:0] SCALE_1       = 2'b00;
    localparam logic [1:0] SCALE_HALF    = 2'b01;
    localparam logic [1:0] SCALE_QUARTER = 2'b10;
    localparam logic [1:0] SCALE_EIGHTH  = 2'b11;

    // Reverse the low 'bits' bits of a sample index (bench helper).
    function automatic logic [11:0] k_bitrev(input logic [11:0] value, input int unsigned bits);
        logic [11:0] result;
        result = '0;
        for (int unsigned i = 0; i < bits; i++) begin
            result[bits-1-i] = value[i];
        end
        return result;
    endfunction

endpackage

// File: rtl/k_fftaddrgen.sv
// Combinational butterfly address map: (stage, butterfly) -> RAM pair and twiddle index.
// Part of the k_fftcontrol slice (option macro K_FFTCTRL_STAGE_SCALE_EN lives in the top).
module k_fftaddrgen
    import k_fft_pkg::*;
#(
    parameter int LOG2N = 5
) (
    input  logic [$clog2(LOG2N+1)-1:0] s,
    input  logic [LOG2N-2:0]           b,
    output logic [LOG2N-1:0]           rd_addr0,
    output logic [LOG2N-1:0]           rd_addr1,
    output logic [LOG2N-2:0]           tw_addr
);

    localparam int SW = $clog2(LOG2N+1);

    logic [LOG2N-1:0] b_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] base;
    logic [LOG2N-2:0] pos_tw;
    logic [SW-1:0]    tw_shift;

    // Split b into group and in-group position, then spread groups by 2h.
    always_comb begin
        b_ext    = {1'b0, b};
        half     = LOG2N'(1) << s;
        pos      = b_ext & (half - 1'b1);
        base     = (b_ext >> s) << (s + 1'b1);
        rd_addr0 = base | pos;
        rd_addr1 = rd_addr0 + half;
        pos_tw   = pos[LOG2N-2:0];
        tw_shift = SW'(LOG2N-1) - s;
        tw_addr  = pos_tw << tw_shift;
    end

endmodule

// File: rtl/k_fftcontrol.sv
// In-place radix-2 DIT FFT sequencer: issues one butterfly per cycle, drains
// between stages and delays write-back addresses by BF_LAT cycles.
// Define K_FFTCTRL_STAGE_SCALE_EN to drive 'scaling' from the latched schedule.
module k_fftcontrol
    import k_fft_pkg::*;
#(
    parameter int LOG2N  = 5,
    parameter int BF_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [2*LOG2N-1:0]           scale_sched,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [LOG2N-1:0]             rd_addr0,
    output logic [LOG2N-1:0]             rd_addr1,
    output logic [LOG2N-2:0]             tw_addr,
    output logic [1:0]                   scaling,
    output logic                         wr_en,
    output logic [LOG2N-1:0]             wr_addr0,
    output logic [LOG2N-1:0]             wr_addr1,
    output logic [$clog2(LOG2N+1)-1:0]   stage
);

    localparam int BW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N + 1);
    localparam int DW = 4;

    k_fftctrl_state_t state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [BW-1:0]    b_q, b_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             accept;

    logic [LOG2N-1:0] a0_d;
    logic [LOG2N-1:0] a1_d;
    logic [LOG2N-2:0] tw_d;
    logic [1:0]       scaling_d;

    logic [BF_LAT-1:0]            wr_en_pipe;
    logic [BF_LAT-1:0][LOG2N-1:0] wa0_pipe;
    logic [BF_LAT-1:0][LOG2N-1:0] wa1_pipe;

    // Sequencer state and stage/butterfly/drain counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            b_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic: walk butterflies, drain BF_LAT cycles after each stage.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        drain_d = drain_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    s_d     = '0;
                    b_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (b_q == {BW{1'b1}}) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DW'(BF_LAT - 1)) begin
                    if (s_q != SW'(LOG2N - 1)) begin
                        s_d     = s_q + 1'b1;
                        b_d     = '0;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    k_fftaddrgen #(
        .LOG2N (LOG2N)
    ) u_addrgen (
        .s        (s_d),
        .b        (b_d),
        .rd_addr0 (a0_d),
        .rd_addr1 (a1_d),
        .tw_addr  (tw_d)
    );

`ifdef K_FFTCTRL_STAGE_SCALE_EN
    logic [2*LOG2N-1:0] sched_q;
    logic [2*LOG2N-1:0] sched_d;
    logic [2*LOG2N-1:0] sched_shifted;

    assign sched_d       = accept ? scale_sched : sched_q;
    assign sched_shifted = sched_d >> {s_d, 1'b0};
    assign scaling_d     = sched_shifted[1:0];

    // Hold the schedule captured when the transform was accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sched_q <= '0;
        end else begin
            sched_q <= sched_d;
        end
    end
`else
    logic unused_sched;

    assign unused_sched = ^{scale_sched, accept};
    assign scaling_d    = SCALE_1;
`endif

    // Registered outputs, computed from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            tw_addr  <= '0;
            scaling  <= SCALE_1;
            stage    <= '0;
        end else begin
            busy     <= (state_d == RUN) || (state_d == DRAIN);
            done     <= (state_d == DONE);
            rd_en    <= (state_d == RUN);
            rd_addr0 <= a0_d;
            rd_addr1 <= a1_d;
            tw_addr  <= tw_d;
            scaling  <= scaling_d;
            stage    <= s_d;
        end
    end

    // Write-back delay line matching the read plus datapath latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_pipe <= '0;
            wa0_pipe   <= '0;
            wa1_pipe   <= '0;
        end else begin
            wr_en_pipe[0] <= rd_en;
            wa0_pipe[0]   <= rd_addr0;
            wa1_pipe[0]   <= rd_addr1;
            for (int i = 1; i < BF_LAT; i++) begin
                wr_en_pipe[i] <= wr_en_pipe[i-1];
                wa0_pipe[i]   <= wa0_pipe[i-1];
                wa1_pipe[i]   <= wa1_pipe[i-1];
            end
        end
    end

    assign wr_en    = wr_en_pipe[BF_LAT-1];
    assign wr_addr0 = wa0_pipe[BF_LAT-1];
    assign wr_addr1 = wa1_pipe[BF_LAT-1];

endmodule

// File: doc/k_fftcontrol.md
# k_fftcontrol

In-place radix-2 decimation-in-time FFT sequencer that drives one `k_floatbutterfly` datapath and a dual-port complex sample RAM. After a start pulse it walks all stages and butterflies and issues one butterfly per cycle: two read addresses, a twiddle ROM address and a scaling code. It delays the write-back addresses to match the datapath latency, inserts drain cycles between stages to prevent read-after-write hazards, and pulses `done` when the transform is complete. Input samples are already in bit-reversed order in the RAM.

## Interface
- `LOG2N`, default 5: transform size N = 2^LOG2N; legal range 2..12.
- `BF_LAT`, default 2: cycles from `rd_en` to the matching `wr_en` (RAM read plus datapath pipeline); legal range 1..8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `scale_sched`  in  2*LOG2N  per-stage scaling codes; stage s uses bits [2s+1:2s]; latched when `start` is accepted.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle completion pulse.
- `rd_en`  out  1  a butterfly issue this cycle.
- `rd_addr0`, `rd_addr1`  out  LOG2N each  RAM read addresses.
- `tw_addr`  out  LOG2N-1  twiddle ROM index.
- `scaling`  out  2  scaling code for the butterfly, aligned with `rd_en`.
- `wr_en`  out  1  write-back strobe.
- `wr_addr0`, `wr_addr1`  out  LOG2N each  write-back addresses.
- `stage`  out  $clog2(LOG2N+1)  current stage index, for debug.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: when `start`=1, latch `scale_sched`, clear s and b, and go to RUN.
- RUN: issue the butterfly (s, b) with `rd_en`=1.
  - If b = N/2-1, go to DRAIN and reset the drain counter.
  - Otherwise b = b+1.
- DRAIN: hold for BF_LAT cycles with `rd_en`=0.
  - When it ends, if s < LOG2N-1: s = s+1, b = 0, go to RUN.
  - Otherwise go to DONE.
- DONE: assert `done` for one cycle, deassert `busy`, and return to IDLE.
- Address rules, with h = 2^s, grp = b>>s, pos = b & (h-1):
  - `rd_addr0` = grp*2h + pos.
  - `rd_addr1` = `rd_addr0` + h.
  - `tw_addr` = pos << (LOG2N-1-s).
  - All arithmetic is unsigned and truncated to the port width.
- `wr_en`, `wr_addr0` and `wr_addr1` are the `rd_en`/`rd_addr0`/`rd_addr1` values delayed by exactly BF_LAT cycles through a shift register. The shift register continues to shift during DRAIN and DONE.
- `start` while not in IDLE is ignored and has no side effects.
- If `start` and `done` occur in the same cycle, the `start` is ignored because the FSM is not yet in IDLE.
- When `rst_n` falls mid-transform, all state clears immediately, pending writes are discarded (`wr_en`=0), and the FSM returns to IDLE.

## Timing
- Reset values: `busy`, `done`, `rd_en` and `wr_en` = 0. All addresses, `scaling` and `stage` = 0.
- All outputs are registered.
- `start` accepted at cycle 0:
  - First `rd_en` is at cycle 1.
  - Each stage occupies N/2 + BF_LAT cycles.
  - The last write of a stage occurs in the final DRAIN cycle. The first read of the next stage follows one cycle later.
  - `done` is at cycle LOG2N*(N/2+BF_LAT)+1; for the defaults, cycle 91.
- Throughput: one butterfly per cycle in RUN, with no stalls.

## Configuration
- `K_FFTCTRL_STAGE_SCALE_EN` defined: `scaling` = latched `scale_sched` field for the current stage.
- Not defined: `scaling` is constant 2'b00 (unity), `scale_sched` is ignored, and no latch register is built.
- The `scale_sched` port exists in both builds.

## Structure
- Package `k_fft_pkg`:
  - FSM state enum `k_fftctrl_state_t`.
  - Scaling code constants SCALE_1, SCALE_HALF, SCALE_QUARTER, SCALE_EIGHTH = 2'b00..2'b11.
  - Function `k_bitrev` for bench use.
- Sub-module `k_fftaddrgen`: combinational map from (s, b) to `rd_addr0`, `rd_addr1` and `tw_addr`; parameterized by LOG2N.
- The delay line is inline in `k_fftcontrol`.

## Test plan
- LOG2N=3, BF_LAT=2, `start` at cycle 0: stage 0 issues (0,1),(2,3),(4,5),(6,7) with `tw_addr` 0,0,0,0.
- Same run, stage 1: (0,2),(1,3),(4,6),(5,7) with `tw_addr` 0,2,0,2. Stage 2: (0,4),(1,5),(2,6),(3,7) with `tw_addr` 0,1,2,3.
- Write alignment and completion:
  - Each `wr_en` and `wr_addr` pair equals the `rd` pair from 2 cycles earlier.
  - No read of stage s+1 occurs at or before the last write of stage s.
  - `done` pulses at cycle 19.
- Defaults with macro on, `scale_sched`=10'b11_10_01_00_01: `scaling` is 01,00,01,10,11 for stages 0..4 and `done` pulses at cycle 91. With macro off, `scaling` stays 00.
- Re-start and reset: `start` pulsed at cycle 10 of a busy run is ignored and `done` timing is unchanged. `rst_n` low at cycle 40 makes `busy`, `rd_en` and `wr_en` 0 immediately. A new `start` then runs a full transform.
